mod_n_sync_counter: RTL and testbench
=====================================

# mod_n_sync_counter

Parametrised synchronous modulo-N counter and the successor to the four-bit ripple counter. All state bits update on the same CLK edge, so there is no ripple skew. It adds:
- configurable width and modulus
- synchronous parallel load
- wrap and one-shot modes
- a registered carry pulse for cascading
- optional up/down counting

Used as the general-purpose counter and timer in the experiment designs: display scanners, frequency dividers, timeouts.

## Interface
- WIDTH, 4, counter width in bits; 1..32.
- MODULUS, 16, count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2**WIDTH.
- ONESHOT, 0, 0 = wrap at terminal value; 1 = stop at terminal value and raise DONE.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
- PAUSE  input  1  hold the current count while high.
- LOAD  input  1  synchronous parallel load.
- D  input  WIDTH  load value.
- DIR  input  1  count direction: 1 = down, 0 = up. Present only with COUNTER_DOWN_EN.
- Q  output  WIDTH  current count, registered.
- CARRY  output  1  one-cycle registered pulse on wrap (ONESHOT=0) or on stop (ONESHOT=1).
- DONE  output  1  ONESHOT=1: sticky stopped flag. ONESHOT=0: tied 0.

## Operation
- Priority per edge: RST > LOAD > (DONE or PAUSE) hold > count.
- RST: Q=0, CARRY=0, DONE=0.
- LOAD:
  - Q=D if D < MODULUS, else Q=MODULUS-1.
  - CARRY=0, DONE=0.
  - LOAD is honoured while PAUSE=1 and while DONE=1.
- Hold: Q, DONE unchanged; CARRY=0.
- Terminal value T: MODULUS-1 counting up, 0 counting down.
- Count, Q≠T: Q±1, CARRY=0.
- Count, Q=T, ONESHOT=0:
  - Q = 0 (up) or MODULUS-1 (down).
  - CARRY=1 for that one cycle.
- Count, Q=T, ONESHOT=1:
  - Q stays T; DONE=1; CARRY=1 for one cycle.
  - Further counting is blocked until LOAD or RST.
- Arithmetic is on WIDTH bits. Compare against MODULUS-1, never against WIDTH overflow, so MODULUS=2**WIDTH wraps naturally.
- Cascading: drive the next stage's PAUSE from the inverted CARRY of the previous stage, with both stages on the same CLK.

## Timing
- Every output is a flop output; no combinational input-to-output paths.
- Latency: an input sampled at edge n is reflected on Q, CARRY and DONE after edge n.
- CARRY is high in exactly the cycle where Q shows the wrapped value (ONESHOT=0), or the first cycle DONE is high (ONESHOT=1).
- PAUSE asserted at the edge where Q=T: no wrap, no CARRY. The wrap happens on the first unpaused edge.
- LOAD of T: no CARRY on the load edge. The next count edge wraps or stops.
- RST or LOAD mid-count overrides any pending wrap on that edge.
- Down counting: T=0, so from Q=0 the counter wraps to MODULUS-1 (or stops at 0 with DONE=1 when ONESHOT=1).
- ONESHOT=1, LOAD(0) after DONE: counting resumes on the following edge.

## Configuration
- COUNTER_DOWN_EN defined:
  - DIR port exists; DIR selects up or down per edge.
  - A DIR change takes effect on the edge where it is sampled.
  - T is re-evaluated against the sampled DIR.
- COUNTER_DOWN_EN undefined:
  - No DIR port; up-count only.
  - Down logic is not synthesised.

## Test plan
- WIDTH=4, MODULUS=10, ONESHOT=0, RST 2 cycles, then free-run 25 cycles -> Q sequence is 0..9,0..9,0..4. CARRY is high only on the two cycles where Q returns to 0.
- Same configuration, PAUSE high for 3 cycles at Q=9 -> Q holds 9 with no CARRY, then wraps to 0 with CARRY on the first unpaused edge.
- LOAD D=7, then LOAD D=12 (out of range) -> Q=7, then Q=9. CARRY=0 on both load edges.
- ONESHOT=1, MODULUS=5, count from 0:
  - expect Q=4 with DONE=1 and CARRY pulsing once, then Q frozen at 4 for 10 cycles;
  - then LOAD D=0 -> DONE=0 and counting restarts.
- COUNTER_DOWN_EN, MODULUS=6, DIR=1 from Q=2 -> Q sequence 1,0,5,4 with CARRY on Q=5. Toggling DIR to 0 at Q=4 -> next value 5.
- Mid-count RST asserted together with LOAD at Q=8 (MODULUS=10) -> Q=0, CARRY=0, DONE=0. RST wins.

Source files
------------

// File: rtl/mod_n_sync_counter_if.sv
// Control and status bundle for mod_n_sync_counter.
// The DIR signal exists only when COUNTER_DOWN_EN is defined.
interface mod_n_sync_counter_if #(
    parameter int WIDTH = 4
);
    // Control inputs are plain levels sampled on every rising clock edge; there is no
    // valid/ready handshake, and status outputs are valid for the whole cycle after that edge.
    logic             pause;
    logic             load;
    logic [WIDTH-1:0] d;
`ifdef COUNTER_DOWN_EN
    logic             dir;
`endif
    logic [WIDTH-1:0] q;
    logic             carry;
    logic             done;

`ifdef COUNTER_DOWN_EN
    modport master (output pause, load, d, dir, input q, carry, done);
    modport slave  (input pause, load, d, dir, output q, carry, done);
`else
    modport master (output pause, load, d, input q, carry, done);
    modport slave  (input pause, load, d, output q, carry, done);
`endif
endinterface

// File: rtl/mod_n_sync_counter.sv
// Synchronous modulo-N counter with load, pause, wrap/one-shot modes and a registered carry.
// Define COUNTER_DOWN_EN to add the DIR input and down counting.
module mod_n_sync_counter #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16,
    parameter bit     ONESHOT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    mod_n_sync_counter_if.slave  bus,
    output logic                 state_dbg
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } state_t;

    // One bit wider than the count so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             carry_reg, carry_next;
    logic [WIDTH-1:0] term, wrap_val, step_val;

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state     <= ST_RUN;
            q_reg     <= '0;
            carry_reg <= 1'b0;
        end else begin
            state     <= state_next;
            q_reg     <= q_next;
            carry_reg <= carry_next;
        end
    end

    always_comb begin : next_state
        q_next     = q_reg;
        carry_next = 1'b0;
        state_next = state;
        term       = TOP;
        wrap_val   = '0;
        step_val   = q_reg + WIDTH'(1);
`ifdef COUNTER_DOWN_EN
        if (bus.dir) begin
            term     = '0;
            wrap_val = TOP;
            step_val = q_reg - WIDTH'(1);
        end
`endif
        if (bus.load) begin
            q_next     = ({1'b0, bus.d} < MOD_EXT) ? bus.d : TOP;
            state_next = ST_RUN;
        end else if (state == ST_STOP || bus.pause) begin
            // hold: count and stop flag keep their value, carry drops
        end else if (q_reg == term) begin
            carry_next = 1'b1;
            if (ONESHOT) begin
                state_next = ST_STOP;
            end else begin
                q_next = wrap_val;
            end
        end else begin
            q_next = step_val;
        end
    end

    always_comb begin : outputs
        bus.q     = q_reg;
        bus.carry = carry_reg;
        bus.done  = ONESHOT && (state == ST_STOP);
        state_dbg = state;
    end
endmodule

// File: tb/tb_mod_n_sync_counter.sv
// Bench for mod_n_sync_counter: wrap, one-shot, full-range and (optionally) down-count instances.
module tb_mod_n_sync_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic dbg0, dbg1, dbg2;

    mod_n_sync_counter_if #(.WIDTH(4)) if0 ();
    mod_n_sync_counter_if #(.WIDTH(4)) if1 ();
    mod_n_sync_counter_if #(.WIDTH(3)) if2 ();

    mod_n_sync_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .bus(if0), .state_dbg(dbg0));
    mod_n_sync_counter #(.WIDTH(4), .MODULUS(5), .ONESHOT(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .bus(if1), .state_dbg(dbg1));
    mod_n_sync_counter #(.WIDTH(3), .MODULUS(8), .ONESHOT(1'b0)) dut2 (
        .clk(clk), .rst(rst2), .bus(if2), .state_dbg(dbg2));

`ifdef COUNTER_DOWN_EN
    logic rst3 = 1'b1;
    logic dbg3;
    mod_n_sync_counter_if #(.WIDTH(4)) if3 ();
    mod_n_sync_counter #(.WIDTH(4), .MODULUS(6), .ONESHOT(1'b0)) dut3 (
        .clk(clk), .rst(rst3), .bus(if3), .state_dbg(dbg3));
`endif

    int total = 0;
    int bad   = 0;
    logic [5:0] exp_q[$];  // {q[3:0], carry, done}

    typedef struct {
        logic       rst;
        logic       load;
        logic       pause;
        logic [3:0] d;
        logic [3:0] q;
        logic       carry;
    } vec_t;
    vec_t tbl[15];

    task automatic check(input string name, input logic [5:0] got);
        logic [5:0] exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no expected entry queued, got q=%0d", name, got[5:2]);
            return;
        end
        exp = exp_q.pop_front();
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got q=%0d carry=%0b done=%0b, want q=%0d carry=%0b done=%0b",
                     name, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic step0(input logic r, input logic l, input logic p, input logic [3:0] dv,
                         input logic [3:0] eq, input logic ec, input string name);
        rst0 = r; if0.load = l; if0.pause = p; if0.d = dv;
        exp_q.push_back({eq, ec, 1'b0});
        @(posedge clk); #1;
        check(name, {if0.q, if0.carry, if0.done});
    endtask

    task automatic step1(input logic r, input logic l, input logic p, input logic [3:0] dv,
                         input logic [3:0] eq, input logic ec, input logic ed, input string name);
        rst1 = r; if1.load = l; if1.pause = p; if1.d = dv;
        exp_q.push_back({eq, ec, ed});
        @(posedge clk); #1;
        check(name, {if1.q, if1.carry, if1.done});
    endtask

    task automatic step2(input logic r, input logic l, input logic [2:0] dv,
                         input logic [3:0] eq, input logic ec, input string name);
        rst2 = r; if2.load = l; if2.pause = 1'b0; if2.d = dv;
        exp_q.push_back({eq, ec, 1'b0});
        @(posedge clk); #1;
        check(name, {1'b0, if2.q, if2.carry, if2.done});
    endtask

`ifdef COUNTER_DOWN_EN
    task automatic step3(input logic r, input logic l, input logic dr, input logic [3:0] dv,
                         input logic [3:0] eq, input logic ec, input string name);
        rst3 = r; if3.load = l; if3.pause = 1'b0; if3.dir = dr; if3.d = dv;
        exp_q.push_back({eq, ec, 1'b0});
        @(posedge clk); #1;
        check(name, {if3.q, if3.carry, if3.done});
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rd;
        // {rst, load, pause, d, expected q, expected carry}; starts from q=1
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 4'd7,  4'd7, 1'b0};  // in-range load
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'd12, 4'd9, 1'b0};  // out-of-range load clamps
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1};  // wrap
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'd9,  4'd9, 1'b0};  // load of T, no carry
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 4'd3,  4'd3, 1'b0};  // load wins over pause
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd3, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'd15, 4'd9, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'd8,  4'd8, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'd5,  4'd0, 1'b0};  // rst beats load
        tbl[10] = '{1'b0, 1'b1, 1'b0, 4'd9,  4'd9, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0};  // rst beats pending wrap
        tbl[12] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 4'd10, 4'd9, 1'b0};  // D == MODULUS clamps
        tbl[14] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1};

        if0.load = 1'b0; if0.pause = 1'b0; if0.d = '0;
        if1.load = 1'b0; if1.pause = 1'b0; if1.d = '0;
        if2.load = 1'b0; if2.pause = 1'b0; if2.d = '0;
`ifdef COUNTER_DOWN_EN
        if3.load = 1'b0; if3.pause = 1'b0; if3.d = '0; if3.dir = 1'b0;
`endif

        // modulus 10, wrap mode
        step0(1, 0, 0, 4'd0, 4'd0, 1'b0, "reset0_a");
        step0(1, 0, 0, 4'd0, 4'd0, 1'b0, "reset0_b");
        for (int k = 1; k <= 25; k++)
            step0(0, 0, 0, 4'd0, 4'(k % 10), (k % 10) == 0, "free_run");
        for (int k = 6; k <= 9; k++)
            step0(0, 0, 0, 4'd0, 4'(k), 1'b0, "count_to_t");
        for (int k = 0; k < 3; k++)
            step0(0, 0, 1, 4'd0, 4'd9, 1'b0, "pause_at_t");
        step0(0, 0, 0, 4'd0, 4'd0, 1'b1, "wrap_after_pause");
        step0(0, 0, 0, 4'd0, 4'd1, 1'b0, "after_wrap");
        for (int i = 0; i < 15; i++)
            step0(tbl[i].rst, tbl[i].load, tbl[i].pause, tbl[i].d, tbl[i].q, tbl[i].carry,
                  $sformatf("vec%0d", i));
        for (int i = 0; i < 8; i++) begin
            rd = 4'($urandom_range(0, 15));
            step0(0, 1, 1'($urandom_range(0, 1)), rd, (rd < 4'd10) ? rd : 4'd9, 1'b0, "rand_load");
        end

        // modulus 5, one-shot mode
        step1(1, 0, 0, 4'd0, 4'd0, 1'b0, 1'b0, "reset1");
        for (int k = 1; k <= 4; k++)
            step1(0, 0, 0, 4'd0, 4'(k), 1'b0, 1'b0, "os_count");
        step1(0, 0, 0, 4'd0, 4'd4, 1'b1, 1'b1, "os_stop");
        total++;
        if (dbg1 !== 1'b1) begin
            bad++;
            $display("FAIL os_state_dbg: got %0b want 1", dbg1);
        end
        for (int k = 0; k < 10; k++)
            step1(0, 0, 0, 4'd0, 4'd4, 1'b0, 1'b1, "os_frozen");
        step1(0, 1, 0, 4'd0, 4'd0, 1'b0, 1'b0, "os_load0");
        step1(0, 0, 0, 4'd0, 4'd1, 1'b0, 1'b0, "os_restart");
        step1(0, 1, 0, 4'd4, 4'd4, 1'b0, 1'b0, "os_load_t");
        step1(0, 0, 0, 4'd0, 4'd4, 1'b1, 1'b1, "os_stop_after_load_t");
        step1(0, 1, 1, 4'd2, 4'd2, 1'b0, 1'b0, "os_load_while_done_paused");
        step1(0, 0, 1, 4'd0, 4'd2, 1'b0, 1'b0, "os_pause");
        step1(0, 0, 0, 4'd0, 4'd3, 1'b0, 1'b0, "os_resume");
        step1(0, 0, 0, 4'd0, 4'd4, 1'b0, 1'b0, "os_reach_t");
        step1(0, 0, 0, 4'd0, 4'd4, 1'b1, 1'b1, "os_stop2");
        step1(1, 1, 0, 4'd1, 4'd0, 1'b0, 1'b0, "os_reset_clears_done");

        // modulus 8 on 3 bits: full-range wrap
        step2(1, 0, 3'd0, 4'd0, 1'b0, "reset2");
        for (int k = 1; k <= 9; k++)
            step2(0, 0, 3'd0, 4'(k % 8), (k % 8) == 0, "full_range");
        step2(0, 1, 3'd7, 4'd7, 1'b0, "full_load7");
        step2(0, 0, 3'd0, 4'd0, 1'b1, "full_wrap");

`ifdef COUNTER_DOWN_EN
        // modulus 6, direction changes
        step3(1, 0, 1, 4'd0, 4'd0, 1'b0, "reset3");
        step3(0, 1, 1, 4'd2, 4'd2, 1'b0, "dn_load2");
        step3(0, 0, 1, 4'd0, 4'd1, 1'b0, "dn_1");
        step3(0, 0, 1, 4'd0, 4'd0, 1'b0, "dn_0");
        step3(0, 0, 1, 4'd0, 4'd5, 1'b1, "dn_wrap");
        step3(0, 0, 1, 4'd0, 4'd4, 1'b0, "dn_4");
        step3(0, 0, 0, 4'd0, 4'd5, 1'b0, "dir_up_5");
        step3(0, 0, 0, 4'd0, 4'd0, 1'b1, "up_wrap");
`endif

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected entries never compared", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
